div_iter: RTL and testbench
===========================

# div_iter

Multi-cycle iterative 32-bit integer divider for the execute stage. It sits directly downstream of the ALU's DIV/DIVU control logic. The ALU raises `start_i` with latched operands and holds the pipeline stalled. This block then runs a radix-2 shift-subtract division and returns `{remainder, quotient}`, which the ALU forwards to HI/LO.

## Interface

Parameters:
- `WIDTH`, default 32: operand width; the result is 2*WIDTH bits.

Ports:
- `clk`, input, 1: clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `signed_div_i`, input, 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i`, input, WIDTH: dividend; sampled with `start_i`.
- `opdata2_i`, input, WIDTH: divisor; sampled with `start_i`.
- `start_i`, input, 1: request. The ALU holds it high until it sees `ready_o`.
- `annul_i`, input, 1: cancel the in-flight division.
- `result_o`, output, 2*WIDTH: `{remainder, quotient}`, valid while `ready_o` is high.
- `ready_o`, output, 1: result valid.

## Operation

- States: IDLE, BYZERO, ON, END. Reset enters IDLE with `result_o=0`, `ready_o=0`, the iteration counter at 0 and the working register at 0.
- **IDLE.** On `start_i=1 && annul_i=0`:
  - Latch `signed_div_i` and both operands.
  - If the divisor is 0, go to BYZERO.
  - Otherwise go to ON with counter 0, and load the working register (2*WIDTH+1 bits) with `{WIDTH'b0, |dividend|, 1'b0}`.
  - Operands are taken as absolute values when signed, and raw when unsigned.
- **ON.** Each cycle with counter < WIDTH does one shift-subtract step:
  - Trial = upper WIDTH+1 bits minus `{1'b0, |divisor|}`.
  - If the trial is negative, shift left with quotient bit 0.
  - Otherwise replace the upper part with the trial and shift in 1.
  - Increment the counter.
- **ON, counter == WIDTH.** Go to END and register the result:
  - quotient = low WIDTH bits of the working register.
  - remainder = upper WIDTH bits of the working register shifted right by 1.
  - Signed correction: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend is negative (the remainder takes the dividend's sign).
  - Set `ready_o=1`.
- **BYZERO.** Go to END next cycle with `result_o=0` (quotient 0, remainder 0) and `ready_o=1`.
- **END.** Hold `result_o` and `ready_o=1` while `start_i=1`. When `start_i=0` is sampled, go to IDLE, clear `result_o` to 0 and drop `ready_o` to 0.
- **annul_i.** `annul_i=1` in ON or BYZERO goes to IDLE without asserting `ready_o`. It is ignored in IDLE and END.
- **Input changes while busy.** Changes to `start_i`, operands or `signed_div_i` in ON or BYZERO are ignored; the latched copies are used.
- **Arithmetic rules:**
  - The absolute value of 0x80000000 is 0x80000000 interpreted as unsigned.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- **Reset.** `rst` asserted in any state returns to IDLE immediately, with all outputs 0.

## Timing

- Edge E0 samples `start_i` in IDLE.
- Normal division:
  - Iterations happen at edges E1..E32.
  - Edge E33 enters END, so `ready_o` is high from E33.
  - Latency is 33 cycles from the sampling edge.
- Divide by zero: BYZERO at E0 and END at E1, so `ready_o` is high from E1.
- `result_o` and `ready_o` are registered outputs, with no combinational path from inputs.
- Release: the ALU drops `start_i` in the cycle it sees `ready_o`. The following edge returns to IDLE. The earliest next start is sampled one edge after that.
- `start_i` re-asserted in the same cycle as the END→IDLE transition is not accepted; it is sampled on the next edge in IDLE.

## Test plan

- **Unsigned, small:** 7 / 2 with `signed_div_i=0` -> after 33 cycles, `ready_o=1` and `result_o=64'h00000001_00000003`. Outputs hold while `start_i=1`, then clear to 0 one edge after `start_i` drops.
- **Signed, mixed signs:**
  - -7 / 2 (0xFFFFFFF9 / 2) -> `result_o=64'hFFFFFFFF_FFFFFFFD`.
  - 7 / -2 -> `64'h00000001_FFFFFFFD`.
- **Extremes:**
  - Unsigned 0xFFFFFFFF / 1 -> `64'h00000000_FFFFFFFF`.
  - Signed 0x80000000 / 0xFFFFFFFF -> `64'h00000000_80000000`.
- **Divide by zero:** 5 / 0 -> `ready_o=1` at E1 with `result_o=0`, and the state never enters ON.
- **Annul and input changes:**
  - Start 100 / 3, then pulse `annul_i` at E10 -> IDLE, `ready_o` never rises.
  - A fresh start of 100 / 3 afterwards -> `64'h00000001_00000021` after 33 cycles.
  - Operands changed mid-division have no effect on the result.
- **Reset mid-operation:** assert `rst` asynchronously at E15 of a division -> `ready_o=0` and `result_o=0` immediately, with no clock edge needed. After release, state is IDLE and a new division completes correctly.

Source files
------------

// File: rtl/div_iter.sv
// Iterative radix-2 shift-subtract divider, signed or unsigned, returning {remainder, quotient}.
// One quotient bit per cycle; the result is registered and held until start_i drops.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0] dvd_abs, dvs_abs, diff, quo, rem;
  logic             trial_neg;

  // Two's complement negation maps the most negative value onto itself, read back as unsigned.
  assign dvd_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign dvs_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // A non-negative trial is below the divisor, so the low WIDTH bits of the difference suffice.
  assign trial_neg = work_q[2*WIDTH:WIDTH] < {1'b0, dvs_q};
  assign diff      = work_q[2*WIDTH-1:WIDTH] - dvs_q;

  assign quo = negq_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem = negr_q ? -work_q[2*WIDTH:WIDTH+1] : work_q[2*WIDTH:WIDTH+1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          negq_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d = signed_div_i & opdata1_i[WIDTH-1];
          dvs_d  = dvs_abs;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            work_d  = {{WIDTH{1'b0}}, dvd_abs, 1'b0};
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != CW'(WIDTH)) begin
          work_d = trial_neg ? {work_q[2*WIDTH-1:0], 1'b0}
                             : {diff, work_q[WIDTH-1:0], 1'b1};
          cnt_d  = cnt_q + CW'(1);
        end else begin
          state_d  = S_END;
          result_d = {rem, quo};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed vector table, multi-cycle corner sequences and randomized
// divisions checked against an arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Truncating division with the remainder taking the dividend's sign; 64-bit math absorbs
  // the most-negative / -1 overflow, which then wraps on truncation to 32 bits.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Returns the number of edges after the sampling edge at which ready was first seen.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [63:0] res, output int lat);
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = n;
        break;
      end
      if (scramble) begin
        op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
      end
    end
    if (lat < 0) begin
      errors++; checks++;
      $display("FAIL timeout: ready never rose for %h / %h", a, b);
    end
    res = result;
  endtask

  task automatic finish_div(input string name, input logic [63:0] res);
    @(posedge clk); #1;
    check({name, " hold"}, {ready, result}, {1'b1, res});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({name, " release"}, {ready, result}, 65'h0);
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    bit          s;
    logic [31:0] a, b;
    bit          seen;

    vt[0] = '{1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 33};
    vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
    vt[2] = '{1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    vt[3] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33};
    vt[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33};
    vt[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33};
    vt[6] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33};
    vt[7] = '{1'b0, 32'd5,        32'd0,        64'h0,                 1};
    vt[8] = '{1'b0, 32'd100,      32'd3,        64'h00000001_00000021, 33};
    vt[9] = '{1'b0, 32'd3,        32'd100,      64'h00000003_00000000, 33};

    #2;
    check("reset outputs", {ready, result}, 65'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      run_div(vt[i].s, vt[i].a, vt[i].b, 1'b0, res, lat);
      check($sformatf("vec%0d result", i), res, vt[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vt[i].lat));
      finish_div($sformatf("vec%0d", i), vt[i].exp);
    end

    // Annul at E10: ready must never rise, then a fresh start completes normally.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'h0);
    run_div(1'b0, 32'd100, 32'd3, 1'b0, res, lat);
    check("post-annul result", res, 64'h00000001_00000021);
    check("post-annul latency", 64'(lat), 64'd33);
    finish_div("post-annul", 64'h00000001_00000021);

    // Operands scrambled after the sampling edge must not matter.
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, res, lat);
    check("scramble result", res, 64'hFFFFFFFE_FFFFFFF2);
    finish_div("scramble", 64'hFFFFFFFE_FFFFFFF2);

    // Asynchronous reset mid-division and while holding a result.
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd3; start = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1; start = 1'b0;
    #1 check("reset mid-op", {ready, result}, 65'h0);
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b0, 32'd7, 32'd2, 1'b0, res, lat);
    check("pre-reset END result", res, 64'h00000001_00000003);
    #2 rst = 1'b1; start = 1'b0;
    #1 check("reset in END", {ready, result}, 65'h0);
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, res, lat);
    check("post-reset result", res, 64'hFFFFFFFF_FFFFFFFD);
    check("post-reset latency", 64'(lat), 64'd33);
    finish_div("post-reset", 64'hFFFFFFFF_FFFFFFFD);

    // Randomized divisions against the reference model.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case (i % 6)
        0:       b = $urandom_range(0, 3);
        1:       b = 32'hFFFFFFFF;
        2:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      if (i % 8 == 7) a = 32'h80000000;
      run_div(s, a, b, i[0], res, lat);
      check($sformatf("rand%0d result s=%0d %h/%h", i, s, a, b), res, model(s, a, b));
      check($sformatf("rand%0d latency", i), 64'(lat), (b == 0) ? 64'd1 : 64'd33);
      finish_div($sformatf("rand%0d", i), model(s, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
